// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART receiver and transmitter: default
// oversampling ratio, default frame width and the receive FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package spart_pkg;

   // Baud-tick enables per bit period and data bits per frame.
   localparam int SPART_OVERSAMPLE = 16;
   localparam int SPART_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } spart_state_e;

endpackage

// File: rtl/spart_sync2.sv
// -----------------------------------------------------------------------------
// spart_sync2
// Two-flop synchronizer for a single asynchronous input. Both flops load
// RESET_VAL on reset so the synchronized output starts from a known level.
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronized output (two clk of latency)
// -----------------------------------------------------------------------------
module spart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx
// Oversampling UART-style receiver. The serial line is synchronized, a start
// bit is qualified at its middle, data bits are sampled at their middles
// (LSB first) and the stop bit is sampled at its middle, at which point the
// byte is moved to the holding register and the FSM returns to IDLE so the
// next start edge can be caught even if the stop bit is short.
//
// Ports:
//   clk           in   system clock, all state on rising edge
//   rst           in   synchronous active-high reset
//   receive_baud  in   one-cycle enable at OVERSAMPLE x bit rate
//   rxd           in   asynchronous serial line, idle high
//   rx_read       in   one-cycle pop of the holding register
//   rx_data       out  holding register, last completed byte
//   rda           out  receive data available
//   framing_err   out  sticky: a stop bit was sampled low
//   overrun_err   out  sticky: a byte completed while rda was already high
//   state_dbg     out  current receive FSM state
//
// Holding-register handshake: rda is the valid flag for rx_data and rx_read
// is the consumer's acknowledge. A pop takes effect only on a cycle where rda
// is high; rx_read while rda is low is ignored. A pop and a new byte landing
// on the same cycle count as "old byte consumed, new byte delivered": rda
// stays high, overrun is not flagged and the error flags restart from this
// frame. All outputs are registered.
// -----------------------------------------------------------------------------
module spart_rx
   import spart_pkg::*;
#(
   parameter int OVERSAMPLE = SPART_OVERSAMPLE,
   parameter int DATA_BITS  = SPART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 receive_baud,
   input  logic                 rxd,
   input  logic                 rx_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rda,
   output logic                 framing_err,
   output logic                 overrun_err,
   output spart_state_e         state_dbg
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   // Half a bit after the start edge is detected, and one full bit later.
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic                 rxd_s;

   spart_state_e         state;
   spart_state_e         state_nxt;
   logic [TW-1:0]        tick_cnt;
   logic [TW-1:0]        tick_nxt;
   logic [BW-1:0]        bit_cnt;
   logic [BW-1:0]        bit_nxt;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_nxt;

   logic                 load;      // stop bit sampled this cycle
   logic                 stop_bad;  // ... and it was low
   logic                 rd_take;   // effective pop

   spart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

   // --------------------------------------------------------------------------
   // FSM and sampling datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_nxt;
         tick_cnt  <= tick_nxt;
         bit_cnt   <= bit_nxt;
         shift_reg <= shift_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic; nothing moves except on baud-tick cycles.
   // --------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      tick_nxt  = tick_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift_reg;
      load      = 1'b0;
      stop_bad  = 1'b0;

      if (receive_baud) begin
         case (state)
            ST_IDLE: begin
               if (!rxd_s) begin
                  state_nxt = ST_START;
                  tick_nxt  = '0;
               end
            end

            ST_START: begin
               if (tick_cnt == TICK_MID) begin
                  tick_nxt = '0;
                  if (!rxd_s) begin
                     state_nxt = ST_DATA;
                     bit_nxt   = '0;
                  end else begin
                     // Line went back high before mid-start: glitch, ignore.
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end

            ST_DATA: begin
               if (tick_cnt == TICK_END) begin
                  shift_nxt = {rxd_s, shift_reg[DATA_BITS-1:1]};
                  tick_nxt  = '0;
                  bit_nxt   = bit_cnt + BW'(1);
                  if (bit_cnt == BIT_LAST) begin
                     state_nxt = ST_STOP;
                  end
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end

            ST_STOP: begin
               if (tick_cnt == TICK_END) begin
                  // Leave at mid-stop so a short stop bit still lets the
                  // next start edge be seen.
                  load      = 1'b1;
                  stop_bad  = !rxd_s;
                  tick_nxt  = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end

            default: begin
               state_nxt = ST_IDLE;
               tick_nxt  = '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Holding register and status flags
   // --------------------------------------------------------------------------
   assign rd_take = rx_read & rda;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data     <= '0;
         rda         <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
      end else if (load) begin
         rx_data <= shift_reg;
         rda     <= 1'b1;
         if (rd_take) begin
            // Previous byte consumed this cycle: flags describe only the new one.
            overrun_err <= 1'b0;
            framing_err <= stop_bad;
         end else begin
            overrun_err <= overrun_err | rda;
            framing_err <= framing_err | stop_bad;
         end
      end else if (rd_take) begin
         rda         <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_spart_rx.sv
// -----------------------------------------------------------------------------
// tb_spart_rx
// Self-checking bench for spart_rx: baud tick every 4 clk (64 clk per bit),
// frames driven bit by bit, a passive monitor pops expected bytes from a
// queue whenever the receiver presents a new byte.
// -----------------------------------------------------------------------------
module tb_spart_rx;
   import spart_pkg::*;

   localparam int W       = 8;
   localparam int BIT_CLK = 64;

   logic         clk;
   logic         rst;
   logic         receive_baud;
   logic         rxd;
   logic         rx_read;
   logic [W-1:0] rx_data;
   logic         rda;
   logic         framing_err;
   logic         overrun_err;
   spart_state_e state_dbg;

   int           total;
   int           bad;
   logic [W-1:0] exp_q[$];
   int           ev;
   int           ev_first;

   spart_rx #(
      .OVERSAMPLE (16),
      .DATA_BITS  (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .receive_baud (receive_baud),
      .rxd          (rxd),
      .rx_read      (rx_read),
      .rx_data      (rx_data),
      .rda          (rda),
      .framing_err  (framing_err),
      .overrun_err  (overrun_err),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / reset / baud tick ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      receive_baud = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         receive_baud = 1'b1;
         @(negedge clk);
         receive_baud = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   // A new byte is presented when rda rises, or when rx_data changes while
   // rda is already high (overwrite).
   initial begin
      logic         rda_prev;
      logic [W-1:0] data_prev;
      logic [W-1:0] exp_b;
      rda_prev  = 1'b0;
      data_prev = '0;
      forever begin
         @(negedge clk);
         if (rda && (!rda_prev || rx_data != data_prev)) begin
            check("byte_was_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
               exp_b = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(exp_b));
            end
         end
         rda_prev  = rda;
         data_prev = rx_data;
      end
   end

   // ---------------- driver tasks ----------------
   // Drives one frame starting on a negedge. The stop bit lasts stop_clk clocks;
   // ev returns the clock index inside the stop bit at which a new byte became
   // visible (0 if none). rx_read is pulsed on the posedge before index read_at.
   task automatic send_frame(input logic [W-1:0] d, input logic stop_val,
                             input int stop_clk, input int read_at, output int ev_o);
      logic         r0;
      logic [W-1:0] d0;
      exp_q.push_back(d);
      rxd = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < W; i++) begin
         rxd = d[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rxd  = stop_val;
      ev_o = 0;
      r0   = rda;
      d0   = rx_data;
      for (int k = 1; k <= stop_clk; k++) begin
         rx_read = (k == read_at);
         @(negedge clk);
         if (ev_o == 0 && rda && (!r0 || rx_data != d0)) ev_o = k;
         r0 = rda;
         d0 = rx_data;
      end
      rx_read = 1'b0;
      rxd     = 1'b1;
   endtask

   task automatic do_read();
      rx_read = 1'b1;
      @(negedge clk);
      rx_read = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      check("sb_drain", 32'(exp_q.size()), 32'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      rxd     = 1'b1;
      rx_read = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_rx_data", 32'(rx_data), 32'(0));
      check("rst_rda", 32'(rda), 32'(0));
      check("rst_framing", 32'(framing_err), 32'(0));
      check("rst_overrun", 32'(overrun_err), 32'(0));
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      idle(64);

      // Basic frame 0xA5 with latency window around the stop-bit middle
      send_frame(8'hA5, 1'b1, BIT_CLK, 0, ev);
      wait_drain(200);
      check("a5_rda", 32'(rda), 32'(1));
      check("a5_framing", 32'(framing_err), 32'(0));
      check("a5_overrun", 32'(overrun_err), 32'(0));
      check("a5_rda_latency_ok", 32'(ev >= 33 && ev <= 40), 32'(1));
      do_read();
      check("a5_read_rda", 32'(rda), 32'(0));
      check("a5_read_hold", 32'(rx_data), 32'(8'hA5));
      do_read();  // pop with nothing available
      check("idle_read_rda", 32'(rda), 32'(0));
      check("idle_read_data", 32'(rx_data), 32'(8'hA5));

      // False start: 3 ticks low, then a real 0x3C frame
      rxd = 1'b0;
      repeat (12) @(negedge clk);
      rxd = 1'b1;
      idle(80);
      check("false_state", 32'(state_dbg), 32'(ST_IDLE));
      check("false_rda", 32'(rda), 32'(0));
      check("false_data", 32'(rx_data), 32'(8'hA5));
      send_frame(8'h3C, 1'b1, BIT_CLK, 0, ev);
      wait_drain(200);
      check("3c_rda", 32'(rda), 32'(1));
      check("3c_framing", 32'(framing_err), 32'(0));
      do_read();

      // Framing error on 0x81
      send_frame(8'h81, 1'b0, BIT_CLK, 0, ev);
      wait_drain(200);
      check("81_rda", 32'(rda), 32'(1));
      check("81_framing", 32'(framing_err), 32'(1));
      check("81_overrun", 32'(overrun_err), 32'(0));
      idle(128);
      check("81_state_idle", 32'(state_dbg), 32'(ST_IDLE));
      do_read();
      check("81_read_rda", 32'(rda), 32'(0));
      check("81_read_framing", 32'(framing_err), 32'(0));

      // Overrun: 0x11 then 0x22 with no read
      send_frame(8'h11, 1'b1, BIT_CLK, 0, ev);
      send_frame(8'h22, 1'b1, BIT_CLK, 0, ev);
      wait_drain(200);
      check("ovr_rda", 32'(rda), 32'(1));
      check("ovr_flag", 32'(overrun_err), 32'(1));
      check("ovr_data", 32'(rx_data), 32'(8'h22));
      do_read();
      check("ovr_read_rda", 32'(rda), 32'(0));
      check("ovr_read_flag", 32'(overrun_err), 32'(0));

      // Same pair, pop landing exactly on the 0x22 load cycle. Frames are
      // back to back and 640 clk long, so tick phase repeats and the load
      // lands at the same offset into the stop bit.
      send_frame(8'h11, 1'b1, BIT_CLK, 0, ev_first);
      check("ovr2_first_seen", 32'(ev_first != 0), 32'(1));
      send_frame(8'h22, 1'b1, BIT_CLK, ev_first, ev);
      wait_drain(200);
      check("ovr2_rda", 32'(rda), 32'(1));
      check("ovr2_flag", 32'(overrun_err), 32'(0));
      check("ovr2_framing", 32'(framing_err), 32'(0));
      do_read();

      // Reset during bit 4 of 0xFF, then 0x5A
      rxd = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      rxd = 1'b1;
      repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
      check("pre_rst_state", 32'(state_dbg), 32'(ST_DATA));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_data", 32'(rx_data), 32'(0));
      check("mid_rst_rda", 32'(rda), 32'(0));
      check("mid_rst_framing", 32'(framing_err), 32'(0));
      check("mid_rst_overrun", 32'(overrun_err), 32'(0));
      check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
      idle(5 * BIT_CLK);
      check("post_rst_no_byte", 32'(rda), 32'(0));
      send_frame(8'h5A, 1'b1, BIT_CLK, 0, ev);
      wait_drain(200);
      check("5a_rda", 32'(rda), 32'(1));
      check("5a_framing", 32'(framing_err), 32'(0));
      check("5a_overrun", 32'(overrun_err), 32'(0));
      do_read();

      // Back-to-back frames, stop bit shortened to just past its middle
      send_frame(8'h00, 1'b1, 44, 0, ev);
      send_frame(8'hFF, 1'b1, 44, 0, ev);
      send_frame(8'h55, 1'b1, BIT_CLK, 0, ev);
      wait_drain(200);
      check("b2b_rda", 32'(rda), 32'(1));
      check("b2b_framing", 32'(framing_err), 32'(0));
      check("b2b_last", 32'(rx_data), 32'(8'h55));
      do_read();
      idle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, baud-tick enables per bit period.
REQ-002 Parameter: DATA_BITS, default 8, data bits per frame.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 receive_baud  input  1  single-cycle enable pulse at OVERSAMPLE x bit rate, from the baud generator.
REQ-007 rxd  input  1  asynchronous serial line, idle high.
REQ-008 rx_read  input  1  consumer pops the holding register; single-cycle pulse.
REQ-009 rx_data  output  DATA_BITS  holding register, last completed byte.
REQ-010 rda  output  1  receive data available.
REQ-011 framing_err  output  1  sticky; stop bit sampled low.
REQ-012 overrun_err  output  1  sticky; byte completed while rda already high.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all sampling uses the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; tick counter 4 bits (log2 OVERSAMPLE), bit counter 3 bits (log2 DATA_BITS).
REQ-015 Counters and FSM SHALL advance only on cycles with receive_baud=1; all other cycles hold state.
REQ-016 IDLE: on a tick with synced rxd=0 -> START, tick counter cleared to 0.
REQ-017 START: each tick increments the counter; on the tick where counter==7, sample: 0 -> DATA with tick and bit counters cleared; 1 -> IDLE (false start, no flag, no output change).
REQ-018 DATA: on the tick where counter==15, sample rxd into a shift register, LSB first, clear tick counter, increment bit counter; after bit DATA_BITS-1 -> STOP.
REQ-019 STOP: on the tick where counter==15, sample stop bit, load shift register into rx_data, set rda, return to IDLE in the same cycle (mid-stop-bit resync).
REQ-020 Stop sample 0 SHALL set framing_err; the byte is still loaded.
REQ-021 Load while rda=1 and no rx_read that cycle SHALL set overrun_err and overwrite rx_data.
REQ-022 rx_read with no concurrent load: next cycle rda=0, framing_err=0, overrun_err=0; rx_data holds its value.
REQ-023 rx_read and load in same cycle: new byte loaded, rda stays 1, overrun_err not set, existing error flags cleared, then framing_err updated from this stop bit.
REQ-024 rx_read while rda=0 SHALL have no effect.
REQ-025 Flag and rda updates SHALL be visible the cycle after the causing edge (registered outputs, no combinational path from inputs).

Reset
REQ-026 On rst=1: state IDLE, counters 0, shift register 0, rx_data=0, rda=0, framing_err=0, overrun_err=0, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL abandon the frame; no partial byte reaches rx_data.
REQ-028 Reset SHALL take priority over receive_baud and rx_read in the same cycle.

Structure
REQ-029 Package spart_pkg SHALL hold the FSM state enum and default OVERSAMPLE/DATA_BITS constants, shared with the transmitter.
REQ-030 One sub-module: spart_sync2 (2-flop synchronizer, reset value parameterized); all else in spart_rx.

Verification
REQ-031 Tick every 4 clk; send 0xA5, stop=1 -> rx_data=0xA5, rda=1, both errors 0, rda rises within 2 clk after stop-bit mid-sample.
REQ-032 rxd low for 3 ticks then high -> FSM back to IDLE, rda=0, rx_data unchanged; following 0x3C frame received correctly.
REQ-033 Send 0x81 with stop bit 0 -> rx_data=0x81, rda=1, framing_err=1; rx_read -> rda=0, framing_err=0 next cycle.
REQ-034 Send 0x11 then 0x22 with no read -> rx_data=0x22, overrun_err=1; repeat with rx_read pulsed exactly on the 0x22 load cycle -> rda=1, overrun_err=0.
REQ-035 Assert rst during bit 4 of 0xFF, then send 0x5A -> after reset all outputs 0, then rx_data=0x5A, no errors.
REQ-036 Back-to-back frames 0x00,0xFF,0x55 with a half-bit stop -> all three received, no framing errors.
